// File: rtl/cpu6_instr_encoder.sv
// Instruction-word encoder: turns field-level requests into 32-bit RV-style words,
// rejects illegal combinations and buffers legal words in a 2-entry output FIFO.
module cpu6_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             illegal,
  output logic [CNT_W-1:0] emitted_cnt
);

  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_OPIMM  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_CSR    = 4'd9;
  localparam logic [3:0] CLS_MRET   = 4'd10;

  logic [31:0]      enc_word_s;
  logic             enc_bad_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      mem_r [2];
  logic             rd_ptr_r;
  logic             wr_ptr_r;
  logic [1:0]       count_r;
  logic             illegal_r;
  logic [CNT_W-1:0] emitted_cnt_r;

  // Field placement and legality check for the presented request
  always_comb begin
    enc_word_s = 32'h0000_0000;
    enc_bad_s  = 1'b0;
    case (in_class)
      CLS_R: begin
        enc_word_s = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'h33};
        if (in_funct7 == 7'h00) begin
          enc_bad_s = 1'b0;
        end else if (in_funct7 == 7'h20) begin
          enc_bad_s = !((in_funct3 == 3'd0) || (in_funct3 == 3'd5));
        end else begin
          enc_bad_s = 1'b1;
        end
      end
      CLS_OPIMM: begin
        enc_word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h13};
        // shift-immediates carry a funct7-like field in imm[11:5]
        if (in_funct3 == 3'd1) begin
          enc_bad_s = (in_imm[11:5] != 7'h00);
        end else if (in_funct3 == 3'd5) begin
          enc_bad_s = !((in_imm[11:5] == 7'h00) || (in_imm[11:5] == 7'h20));
        end else begin
          enc_bad_s = 1'b0;
        end
      end
      CLS_LOAD: begin
        enc_word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h03};
        enc_bad_s  = (in_funct3 == 3'd3) || (in_funct3 == 3'd6) || (in_funct3 == 3'd7);
      end
      CLS_STORE: begin
        enc_word_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'h23};
        enc_bad_s  = (in_funct3 > 3'd2);
      end
      CLS_BRANCH: begin
        enc_word_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], 7'h63};
        enc_bad_s  = (in_funct3 == 3'd2) || (in_funct3 == 3'd3) || in_imm[0];
      end
      CLS_JAL: begin
        enc_word_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
        enc_bad_s  = in_imm[0];
      end
      CLS_JALR: begin
        enc_word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h67};
        enc_bad_s  = (in_funct3 != 3'd0);
      end
      CLS_LUI: begin
        enc_word_s = {in_imm[31:12], in_rd, 7'h37};
      end
      CLS_AUIPC: begin
        enc_word_s = {in_imm[31:12], in_rd, 7'h17};
      end
      CLS_CSR: begin
        enc_word_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h73};
        enc_bad_s  = (in_funct3 == 3'd0) || (in_funct3 == 3'd4);
      end
      CLS_MRET: begin
        enc_word_s = 32'h3020_0073;
      end
      default: begin
        enc_bad_s = 1'b1;
      end
    endcase
  end

  // in_ready depends only on flush and registered occupancy, never on out_ready
  assign in_ready  = !flush && (count_r != 2'd2);
  assign accept_s  = in_valid && in_ready;
  assign push_s    = accept_s && !enc_bad_s;
  assign pop_s     = (count_r != 2'd0) && out_ready;

  assign out_valid   = (count_r != 2'd0);
  assign out_instr   = (count_r != 2'd0) ? mem_r[rd_ptr_r] : 32'h0000_0000;
  assign illegal     = illegal_r;
  assign emitted_cnt = emitted_cnt_r;

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r[0] <= 32'h0000_0000;
      mem_r[1] <= 32'h0000_0000;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= enc_word_s;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Illegal-request pulse and transferred-word counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_r     <= 1'b0;
      emitted_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      illegal_r     <= 1'b0;
      emitted_cnt_r <= emitted_cnt_r;
    end else begin
      illegal_r <= accept_s && enc_bad_s;
      if (pop_s) begin
        emitted_cnt_r <= emitted_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        emitted_cnt_r <= emitted_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_cpu6_instr_encoder.sv
// Self-checking bench for cpu6_instr_encoder: directed vectors, backpressure, illegal,
// flush and async-reset scenarios plus randomized requests against a reference encoder.
module tb_cpu6_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = 4'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        illegal;
  logic [15:0] emitted_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [15:0] exp_cnt = 16'd0;

  cpu6_instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .illegal(illegal), .emitted_cnt(emitted_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got %h, required no output", out_instr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_instr !== mon_exp) begin
          n_bad++;
          $display("FAIL out_instr: got %h, required %h", out_instr, mon_exp);
        end
      end
    end
  end

  // Reference encoder written directly from the field-placement and legality rules
  function automatic logic [32:0] ref_encode(input logic [3:0] c, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    logic        bad;
    w = 32'd0;
    bad = 1'b0;
    case (c)
      4'd0: begin
        w = {f7, rs2, rs1, f3, rd, 7'h33};
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      4'd1: begin
        w = {imm[11:0], rs1, f3, rd, 7'h13};
        bad = (f3 == 3'd1 && imm[11:5] != 7'h00) ||
              (f3 == 3'd5 && imm[11:5] != 7'h00 && imm[11:5] != 7'h20);
      end
      4'd2: begin w = {imm[11:0], rs1, f3, rd, 7'h03}; bad = (f3 == 3'd3 || f3 >= 3'd6); end
      4'd3: begin w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23}; bad = (f3 >= 3'd3); end
      4'd4: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
        bad = (f3 == 3'd2 || f3 == 3'd3 || imm[0] == 1'b1);
      end
      4'd5: begin w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F}; bad = imm[0]; end
      4'd6: begin w = {imm[11:0], rs1, f3, rd, 7'h67}; bad = (f3 != 3'd0); end
      4'd7: w = {imm[31:12], rd, 7'h37};
      4'd8: w = {imm[31:12], rd, 7'h17};
      4'd9: begin w = {imm[11:0], rs1, f3, rd, 7'h73}; bad = (f3 == 3'd0 || f3 == 3'd4); end
      4'd10: w = 32'h30200073;
      default: bad = 1'b1;
    endcase
    return {bad, w};
  endfunction

  // Present one request, wait (bounded) for acceptance, and check the illegal pulse
  task automatic send(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input logic [31:0] exp_w, input logic exp_bad);
    bit done = 1'b0;
    in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1'b1;
        if (!exp_bad) begin
          exp_q.push_back(exp_w);
          exp_cnt = exp_cnt + 16'd1;
        end
      end else begin
        @(posedge clk); #1;
        if (k >= 3) out_ready = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      in_valid = 1'b0;
      $display("FAIL send_timeout: in_ready got %b, required 1", in_ready);
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (illegal !== exp_bad) begin
        n_bad++;
        $display("FAIL illegal_pulse class %0d: got %b, required %b", c, illegal, exp_bad);
      end
    end
  endtask

  // Let the FIFO empty and check the transfer counter
  task automatic drain();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && out_valid === 1'b0) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain_timeout: pending %0d, out_valid %b, required empty", exp_q.size(), out_valid);
    end
    n_cmp++;
    if (emitted_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL emitted_cnt_drain: got %0d, required %0d", emitted_cnt, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_out_instr: got %h, required 0", out_instr); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal: got %b, required 0", illegal); end
    n_cmp++; if (emitted_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_emitted: got %0d, required 0", emitted_cnt); end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_valid: got %b, required 1", out_valid); end
    n_cmp++; if (out_instr !== 32'h00500093) begin n_bad++; $display("FAIL latency_instr: got %h, required 00500093", out_instr); end
    @(posedge clk); #1;
    n_cmp++; if (emitted_cnt !== 16'd1) begin n_bad++; $display("FAIL first_count: got %0d, required 1", emitted_cnt); end
    send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0);
    send(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0020A423, 1'b0);
    send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8, 32'h00208463, 1'b0);
    send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16, 32'h010000EF, 1'b0);
    send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
    send(4'd10, 5'd7, 5'd9, 5'd3, 3'd1, 7'h55, 32'h0000FFFF, 32'h30200073, 1'b0);
    send(4'd2, 5'd4, 5'd2, 5'd9, 3'd2, 7'h7F, 32'hFFFFF010, 32'h01012203, 1'b0);
    send(4'd1, 5'd2, 5'd1, 5'd0, 3'd5, 7'h00, 32'h00000403, 32'h4030D113, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0);
    in_class = 4'd7; in_rd = 5'd5; in_imm = 32'h12345000; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
    end
    n_cmp++; if (out_instr !== 32'h00500093) begin n_bad++; $display("FAIL full_head: got %h, required 00500093", out_instr); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(4'd4, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_branch_valid: got %b, required 0", out_valid); end
    send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'h0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_jal_valid: got %b, required 0", out_valid); end
    send(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd0, 32'h0, 1'b1);
    send(4'd6, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'd0, 32'h0, 1'b1);
    send(4'd0, 5'd1, 5'd1, 5'd2, 3'd1, 7'h20, 32'd0, 32'h0, 1'b1);
    send(4'd9, 5'd1, 5'd1, 5'd0, 3'd4, 7'h00, 32'h300, 32'h0, 1'b1);
    send(4'd1, 5'd1, 5'd1, 5'd0, 3'd5, 7'h00, 32'h200, 32'h0, 1'b1);
    @(posedge clk); #1;
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_one_cycle: got %b, required 0", illegal); end
    n_cmp++; if (emitted_cnt !== exp_cnt) begin n_bad++; $display("FAIL illegal_count: got %0d, required %0d", emitted_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0);
    exp_cnt = exp_cnt - 16'd2;
    flush = 1'b1; out_ready = 1'b1;
    in_class = 4'd1; in_rd = 5'd1; in_imm = 32'd7; in_funct3 = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
    n_cmp++; if (emitted_cnt !== exp_cnt) begin n_bad++; $display("FAIL flush_count: got %0d, required %0d", emitted_cnt, exp_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_accept: got %b, required 0", out_valid); end
  endtask

  task automatic test_random();
    logic [32:0] r;
    logic [3:0]  c;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom_range(0, 15));
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      imm = $urandom;
      if ($urandom_range(0, 1) == 1) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      r = ref_encode(c, rd, rs1, rs2, f3, f7, imm);
      send(c, rd, rs1, rs2, f3, f7, imm, r[31:0], r[32]);
    end
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
    send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16, 32'h010000EF, 1'b0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_cnt = 16'd0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b, required 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL arst_instr: got %h, required 0", out_instr); end
    n_cmp++; if (emitted_cnt !== 16'd0) begin n_bad++; $display("FAIL arst_count: got %0d, required 0", emitted_cnt); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL arst_illegal: got %b, required 0", illegal); end
    out_ready = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_discard: got %b, required 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu6_instr_encoder.md
CPU6_INSTR_ENCODER -- requirements
Module: cpu6_instr_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the emitted-instruction counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid / in_ready, input / output, 1 / 1, request handshake.
REQ-005 SHALL have port in_class, input, 4, encoding class: 0 R (0x33), 1 OP-IMM (0x13), 2 LOAD (0x03), 3 STORE (0x23), 4 BRANCH (0x63), 5 JAL (0x6F), 6 JALR (0x67), 7 LUI (0x37), 8 AUIPC (0x17), 9 CSR (0x73), 10 MRET; 11-15 illegal.
REQ-006 SHALL have ports in_rd/in_rs1/in_rs2, input, 5 each; in_funct3, input, 3; in_funct7, input, 7; in_imm, input, 32; CSR address taken from in_imm[11:0], CSR uimm from in_rs1.
REQ-007 SHALL have port flush, input, 1, synchronous clear of buffered output.
REQ-008 SHALL have port out_valid / out_ready, output / input, 1 / 1, instruction handshake; out_instr, output, 32, encoded word.
REQ-009 SHALL have port illegal, output, 1, one-cycle pulse per rejected request.
REQ-010 SHALL have port emitted_cnt, output, CNT_W, count of words transferred on output.

Function
REQ-011 Request accepted on a clk edge where in_valid && in_ready.
REQ-012 in_ready = !flush && (buffer occupancy < 2); no combinational path from out_ready to in_ready.
REQ-013 Output buffer SHALL be a 2-entry FIFO; out_instr = head entry; out_valid = occupancy != 0.
REQ-014 Latency: a legal accepted word appears on out_valid/out_instr the cycle after acceptance when buffer was empty.
REQ-015 Simultaneous accept and pop SHALL keep occupancy unchanged and preserve order.
REQ-016 Field placement: R = funct7|rs2|rs1|f3|rd|op; I/LOAD/JALR = imm[11:0]|rs1|f3|rd|op; STORE = imm[11:5]|rs2|rs1|f3|imm[4:0]|op; BRANCH = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; U = imm[31:12]|rd|op; JAL = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op; CSR = imm[11:0]|rs1|f3|rd|op; MRET = 0x30200073 fixed.
REQ-017 Immediate bits outside the encoded field SHALL be ignored (no range check).
REQ-018 Illegal: class 11-15; BRANCH f3 2/3; LOAD f3 3/6/7; STORE f3 >2; JALR f3 !=0; R funct7 not 0x00/0x20, or 0x20 with f3 not 0/5; OP-IMM f3=1 with imm[11:5]!=0, f3=5 with imm[11:5] not 0x00/0x20; CSR f3 0 or 4; BRANCH/JAL imm[0]=1.
REQ-019 Illegal request SHALL be accepted (handshake completes), not enqueued, and pulse illegal in the following cycle.
REQ-020 Fields ignored by a class (e.g., funct7 for LOAD) SHALL not affect legality or output.
REQ-021 flush SHALL empty the FIFO next edge; a pop in the same cycle is discarded and not counted; a request in that cycle is not accepted (in_ready low).
REQ-022 emitted_cnt increments by 1 per out_valid && out_ready (not during flush), wraps modulo 2^CNT_W.

Reset
REQ-023 reset asserted SHALL immediately clear FIFO, out_valid=0, out_instr=0, illegal=0, emitted_cnt=0; in_ready=1 after deassert.
REQ-024 reset mid-transfer SHALL discard all buffered words without output.

Verification
REQ-025 class1 rd=1 rs1=0 f3=0 imm=5, out_ready=1 -> next cycle out_instr=0x00500093, emitted_cnt=1.
REQ-026 class0 rd=3 rs1=1 rs2=2 f3=0 f7=0 -> 0x002081B3; class3 rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423.
REQ-027 class4 rs1=1 rs2=2 f3=0 imm=8 -> 0x00208463; class5 rd=1 imm=16 -> 0x010000EF; class7 rd=5 imm=0x12345000 -> 0x123452B7; class10 -> 0x30200073.
REQ-028 out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 on third until one pop; order preserved.
REQ-029 class4 f3=2, then class5 imm=3 -> two illegal pulses, no out_valid, emitted_cnt unchanged.
REQ-030 FIFO holding 2 words, flush=1 with out_ready=1 -> out_valid=0 next cycle, emitted_cnt unchanged; async reset mid-stream -> all outputs 0 immediately.
